// File: rtl/voice_alloc.sv
// Polyphony scheduler: assigns key press/release events to tone-generator voice slots,
// lowest-free-first, stealing the oldest voice when every slot is busy.
module voice_alloc #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned AGE_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ev_valid,
    output logic                    ev_ready,
    input  logic                    ev_on,
    input  logic [7:0]              ev_noteid,
    output logic [8*NUM_VOICES-1:0] voice_noteid,
    output logic [NUM_VOICES-1:0]   voice_busy,
    output logic [4:0]              active_count,
    output logic                    done,
    output logic                    steal,
    output logic                    retrig
);
    localparam int unsigned IdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    typedef logic [IdxW-1:0] idx_t;
    typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

    state_e state_q, state_d;

    logic                 ev_on_q, ev_on_d;
    logic [7:0]           id_q, id_d;
    idx_t                 idx_q, idx_d;
    logic                 match_q, match_d;
    idx_t                 match_idx_q, match_idx_d;
    logic                 free_q, free_d;
    idx_t                 free_idx_q, free_idx_d;
    logic                 old_q, old_d;
    idx_t                 old_idx_q, old_idx_d;
    logic [AGE_WIDTH-1:0] old_age_q, old_age_d;

    logic [7:0]           noteid_q [NUM_VOICES];
    logic [7:0]           noteid_d [NUM_VOICES];
    logic [AGE_WIDTH-1:0] age_q [NUM_VOICES];
    logic [AGE_WIDTH-1:0] age_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] busy_q, busy_d;
    logic [4:0]           count_q, count_d;
    logic                 done_q, done_d, steal_q, steal_d, retrig_q, retrig_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ev_ready = (state_q == StIdle);
        unique case (state_q)
            StIdle:   if (ev_valid) state_d = StScan;
            StScan:   if (idx_q == idx_t'(NUM_VOICES - 1)) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Event latch and one-slot-per-cycle scan
    always_comb begin
        ev_on_d     = ev_on_q;
        id_d        = id_q;
        idx_d       = idx_q;
        match_d     = match_q;
        match_idx_d = match_idx_q;
        free_d      = free_q;
        free_idx_d  = free_idx_q;
        old_d       = old_q;
        old_idx_d   = old_idx_q;
        old_age_d   = old_age_q;
        if (state_q == StIdle && ev_valid) begin
            ev_on_d = ev_on;
            id_d    = ev_noteid;
            idx_d   = '0;
            match_d = 1'b0;
            free_d  = 1'b0;
            old_d   = 1'b0;
        end else if (state_q == StScan) begin
            if (idx_q != idx_t'(NUM_VOICES - 1)) idx_d = idx_q + idx_t'(1);
            if (busy_q[idx_q] && noteid_q[idx_q] == id_q && !match_q) begin
                match_d     = 1'b1;
                match_idx_d = idx_q;
            end
            if (!busy_q[idx_q] && !free_q) begin
                free_d     = 1'b1;
                free_idx_d = idx_q;
            end
            // Strict '>' keeps the lowest index on age ties
            if (busy_q[idx_q] && (!old_q || age_q[idx_q] > old_age_q)) begin
                old_d     = 1'b1;
                old_idx_d = idx_q;
                old_age_d = age_q[idx_q];
            end
        end
    end

    always_comb begin
        idx_t tgt;
        noteid_d = noteid_q;
        age_d    = age_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        steal_d  = 1'b0;
        retrig_d = 1'b0;
        tgt      = '0;
        if (state_q == StCommit) begin
            done_d = 1'b1;
            if (id_q != 8'd0) begin
                if (ev_on_q) begin
                    if (match_q) begin
                        tgt      = match_idx_q;
                        retrig_d = 1'b1;
                    end else if (free_q) begin
                        tgt = free_idx_q;
                        busy_d[tgt] = 1'b1;
                    end else begin
                        tgt     = old_idx_q;
                        steal_d = 1'b1;
                    end
                    noteid_d[tgt] = id_q;
                    for (int k = 0; k < int'(NUM_VOICES); k++) begin
                        if (idx_t'(k) == tgt) begin
                            age_d[k] = '0;
                        end else if (busy_q[k] && age_q[k] != '1) begin
                            age_d[k] = age_q[k] + AGE_WIDTH'(1);
                        end
                    end
                end else if (match_q) begin
                    noteid_d[match_idx_q] = 8'd0;
                    busy_d[match_idx_q]   = 1'b0;
                    age_d[match_idx_q]    = '0;
                end
            end
        end
        count_d = '0;
        for (int k = 0; k < int'(NUM_VOICES); k++) count_d = count_d + 5'(busy_d[k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_on_q     <= 1'b0;
            id_q        <= '0;
            idx_q       <= '0;
            match_q     <= 1'b0;
            match_idx_q <= '0;
            free_q      <= 1'b0;
            free_idx_q  <= '0;
            old_q       <= 1'b0;
            old_idx_q   <= '0;
            old_age_q   <= '0;
            for (int k = 0; k < int'(NUM_VOICES); k++) begin
                noteid_q[k] <= '0;
                age_q[k]    <= '0;
            end
            busy_q   <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            steal_q  <= 1'b0;
            retrig_q <= 1'b0;
        end else begin
            ev_on_q     <= ev_on_d;
            id_q        <= id_d;
            idx_q       <= idx_d;
            match_q     <= match_d;
            match_idx_q <= match_idx_d;
            free_q      <= free_d;
            free_idx_q  <= free_idx_d;
            old_q       <= old_d;
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
            noteid_q    <= noteid_d;
            age_q       <= age_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
            done_q      <= done_d;
            steal_q     <= steal_d;
            retrig_q    <= retrig_d;
        end
    end

    always_comb begin
        voice_noteid = '0;
        for (int k = 0; k < int'(NUM_VOICES); k++) voice_noteid[8*k +: 8] = noteid_q[k];
    end

    assign voice_busy   = busy_q;
    assign active_count = count_q;
    assign done         = done_q;
    assign steal        = steal_q;
    assign retrig       = retrig_q;
endmodule
